// File: rtl/bram_fifo_pkg.sv
// Shared constants and helpers for the BRAM-backed FIFO controller.
// Used by both the default build and builds with BRAM_FIFO_FLAGS_EN.
package bram_fifo_pkg;

  localparam int unsigned OB_DEPTH = 2;

  // Operation seen by the output buffer in one cycle: {capture, pop}.
  typedef enum logic [1:0] {
    OB_IDLE    = 2'b00,
    OB_POP     = 2'b01,
    OB_CAP     = 2'b10,
    OB_CAP_POP = 2'b11
  } ob_op_e;

  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Level counts RAM + in-flight read + output buffer, up to depth + 2.
  function automatic int unsigned level_width(input int unsigned addr_w);
    return addr_w + 32'd2;
  endfunction

endpackage

// File: rtl/bram_fifo_obuf.sv
// Two-entry output buffer that absorbs the RAM read latency.
// The head register drives m_data directly and holds its value when empty.
module bram_fifo_obuf
  import bram_fifo_pkg::*;
#(
  parameter int G_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cap_valid,
  input  logic [G_WIDTH-1:0] cap_data,
  input  logic               pop,
  output logic               m_valid,
  output logic [G_WIDTH-1:0] m_data,
  output logic [1:0]         ob_cnt
);

  localparam logic [1:0] FULL_CNT = 2'(OB_DEPTH);

  logic [G_WIDTH-1:0] slot1;
  ob_op_e             op;

  always_comb begin
    op = ob_op_e'({cap_valid, pop});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ob_cnt  <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      slot1   <= '0;
    end else begin
      case (op)
        OB_CAP: begin
          if (ob_cnt == 2'd0) m_data <= cap_data;
          else                slot1  <= cap_data;
          ob_cnt  <= ob_cnt + 2'd1;
          m_valid <= 1'b1;
        end
        OB_POP: begin
          // With a single entry the head is left untouched so m_data holds.
          if (ob_cnt == FULL_CNT) m_data <= slot1;
          ob_cnt  <= ob_cnt - 2'd1;
          m_valid <= (ob_cnt == FULL_CNT);
        end
        OB_CAP_POP: begin
          if (ob_cnt == FULL_CNT) begin
            m_data <= slot1;
            slot1  <= cap_data;
          end else begin
            m_data <= cap_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(op == OB_CAP && ob_cnt == FULL_CNT))
        else $error("bram_fifo_obuf: capture into full output buffer");
    end
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller around an external 1-cycle-latency dual-port BRAM (A write, B read).
// Define BRAM_FIFO_FLAGS_EN to add almost_full/almost_empty and sticky overflow/underflow.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int G_ADDR   = 6,
  parameter int G_WIDTH  = 16,
  parameter int G_AFULL  = 56,
  parameter int G_AEMPTY = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [G_WIDTH-1:0]  s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [G_WIDTH-1:0]  m_data,
  output logic [G_ADDR+1:0]   level,
`ifdef BRAM_FIFO_FLAGS_EN
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow,
`endif
  output logic                ram_wea,
  output logic [G_ADDR-1:0]   ram_addra,
  output logic [G_WIDTH-1:0]  ram_dia,
  output logic [G_ADDR-1:0]   ram_addrb,
  input  logic [G_WIDTH-1:0]  ram_dob
);

  localparam int unsigned D  = fifo_depth(G_ADDR);
  localparam int unsigned LW = level_width(G_ADDR);

  typedef logic [G_ADDR:0] cnt_t;
  typedef logic [LW-1:0]   level_t;

  logic [G_ADDR-1:0] wptr, rptr;
  cnt_t              ram_cnt, ram_cnt_nxt;
  logic              rd_inflight;
  logic [1:0]        ob_cnt, ob_cnt_nxt;
  level_t            level_nxt;
  logic              push, pop, issue;

  always_comb begin
    push        = s_valid & s_ready;
    pop         = m_valid & m_ready;
    // pop implies ob_cnt >= 1, so this never underflows.
    ob_cnt_nxt  = ob_cnt + {1'b0, rd_inflight} - {1'b0, pop};
    issue       = (ram_cnt != '0) && (ob_cnt_nxt < 2'(OB_DEPTH));
    ram_cnt_nxt = ram_cnt + cnt_t'(push) - cnt_t'(issue);
    level_nxt   = level_t'(ram_cnt_nxt) + level_t'(issue) + level_t'(ob_cnt_nxt);
  end

  assign ram_wea   = push;
  assign ram_addra = wptr;
  assign ram_dia   = s_data;
  assign ram_addrb = rptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
      s_ready     <= 1'b0;
      level       <= '0;
    end else begin
      if (push)  wptr <= wptr + 1'b1;
      if (issue) rptr <= rptr + 1'b1;
      ram_cnt     <= ram_cnt_nxt;
      rd_inflight <= issue;
      s_ready     <= (ram_cnt_nxt < cnt_t'(D));
      level       <= level_nxt;
    end
  end

  bram_fifo_obuf #(
    .G_WIDTH (G_WIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_valid (rd_inflight),
    .cap_data  (ram_dob),
    .pop       (pop),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .ob_cnt    (ob_cnt)
  );

`ifdef BRAM_FIFO_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      almost_full  <= (level_nxt >= level_t'(G_AFULL));
      almost_empty <= (level_nxt <= level_t'(G_AEMPTY));
      if (s_valid && !s_ready) overflow  <= 1'b1;
      if (m_ready && !m_valid) underflow <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (G_AEMPTY < G_AFULL && G_AFULL <= int'(D + OB_DEPTH))
        else $error("bram_fifo_ctrl: inconsistent flag thresholds");
      assert (!(push && issue && wptr == rptr))
        else $error("bram_fifo_ctrl: read/write address collision");
    end
  end

endmodule
